// File: rtl/dffsre_ift_pkg.sv
// Shared types and helpers for the IFT set/clear/enable DFF response monitor.
package dffsre_ift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int TW_DEF = 32;
  // The taint helper works on the widest supported vector; callers zero-extend and truncate.
  localparam int TW_MAX = 64;

  function automatic logic [TW_MAX-1:0] taint_or3(input logic [TW_MAX-1:0] a,
                                                  input logic [TW_MAX-1:0] b,
                                                  input logic [TW_MAX-1:0] c);
    return a | b | c;
  endfunction

endpackage

// File: rtl/dffsre_ift_model.sv
// Shadow model of the instrumented set/clear/enable DFF: tracks the expected value and taint of Q.
module dffsre_ift_model
  import dffsre_ift_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_upd,
  input  logic          i_d,
  input  logic [TW-1:0] i_d_t,
  input  logic          i_en,
  input  logic [TW-1:0] i_en_t,
  input  logic          i_set,
  input  logic [TW-1:0] i_set_t,
  input  logic          i_clr,
  input  logic [TW-1:0] i_clr_t,
  input  logic [TW-1:0] i_clk_t,
  input  logic          i_q,
  input  logic [TW-1:0] i_q_t,
  output logic          o_q,
  output logic [TW-1:0] o_qt
);

  logic          r_q;
  logic [TW-1:0] r_qt;
  logic [TW-1:0] w_set_qt;
  logic [TW-1:0] w_en_qt;
  logic [TW-1:0] w_hold_qt;

  assign w_set_qt  = TW'(taint_or3(TW_MAX'(i_set_t), TW_MAX'(i_clr_t), '0));
  assign w_en_qt   = TW'(taint_or3(TW_MAX'(i_d_t), TW_MAX'(i_en_t), TW_MAX'(i_clk_t)));
  assign w_hold_qt = TW'(taint_or3(TW_MAX'(r_qt), TW_MAX'(i_en_t), TW_MAX'(i_clk_t)));

  // Clear outranks set, set outranks enable; a held Q still picks up enable/clock taint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= 1'b0;
      r_qt <= '0;
    end else if (i_load) begin
      r_q  <= i_q;
      r_qt <= i_q_t;
    end else if (i_upd) begin
      if (i_clr) begin
        r_q  <= 1'b0;
        r_qt <= i_clr_t;
      end else if (i_set) begin
        r_q  <= 1'b1;
        r_qt <= w_set_qt;
      end else if (i_en) begin
        r_q  <= i_d;
        r_qt <= w_en_qt;
      end else begin
        r_qt <= w_hold_qt;
      end
    end
  end

  assign o_q  = r_q;
  assign o_qt = r_qt;

endmodule

// File: rtl/dffsre_ift_monitor.sv
// Passive checker for an IFT-instrumented DFF: compares Q/Q_t with a shadow model every RUN cycle.
module dffsre_ift_monitor
  import dffsre_ift_pkg::*;
#(
  parameter int TW          = TW_DEF,
  parameter int CW          = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          START,
  input  logic          STOP,
  input  logic          OBS_D,
  input  logic [TW-1:0] OBS_D_t,
  input  logic          OBS_EN,
  input  logic [TW-1:0] OBS_EN_t,
  input  logic          OBS_SET,
  input  logic [TW-1:0] OBS_SET_t,
  input  logic          OBS_CLR,
  input  logic [TW-1:0] OBS_CLR_t,
  input  logic [TW-1:0] OBS_CLK_t,
  input  logic          OBS_Q,
  input  logic [TW-1:0] OBS_Q_t,
  output logic          ERR,
  output logic          ERR_VAL,
  output logic          ERR_TNT,
  output logic [CW-1:0] CHK_CNT,
  output logic [CW-1:0] ERR_CNT,
  output logic [CW-1:0] FIRST_ERR,
  output logic          DONE
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  state_t        r_state;
  logic          r_async_prev;
  logic [CW-1:0] r_cyc;
  logic          r_err;
  logic          r_err_val;
  logic          r_err_tnt;
  logic [CW-1:0] r_chk_cnt;
  logic [CW-1:0] r_err_cnt;
  logic [CW-1:0] r_first_err;
  logic          r_done;

  logic          w_q;
  logic [TW-1:0] w_qt;
  logic          w_skip;
  logic          w_cmp;
  logic          w_val_mis;
  logic          w_tnt_mis;
  logic          w_mis;

  dffsre_ift_model #(.TW(TW)) u_model (
    .clk     (CLK),
    .rst     (CLR),
    .i_load  (r_state == SYNC),
    .i_upd   (r_state == RUN),
    .i_d     (OBS_D),
    .i_d_t   (OBS_D_t),
    .i_en    (OBS_EN),
    .i_en_t  (OBS_EN_t),
    .i_set   (OBS_SET),
    .i_set_t (OBS_SET_t),
    .i_clr   (OBS_CLR),
    .i_clr_t (OBS_CLR_t),
    .i_clk_t (OBS_CLK_t),
    .i_q     (OBS_Q),
    .i_q_t   (OBS_Q_t),
    .o_q     (w_q),
    .o_qt    (w_qt)
  );

  // Async set/clear can move Q between edges, so this edge and the one after are not compared.
  assign w_skip    = OBS_SET | OBS_CLR | r_async_prev;
  assign w_cmp     = (r_state == RUN) && !w_skip;
  assign w_val_mis = (OBS_Q !== w_q);
  assign w_tnt_mis = (OBS_Q_t !== w_qt);
  assign w_mis     = w_cmp && (w_val_mis || w_tnt_mis);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state      <= IDLE;
      r_async_prev <= 1'b0;
      r_cyc        <= '0;
      r_err        <= 1'b0;
      r_err_val    <= 1'b0;
      r_err_tnt    <= 1'b0;
      r_chk_cnt    <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
      r_done       <= 1'b0;
    end else begin
      r_async_prev <= OBS_SET | OBS_CLR;
      case (r_state)
        IDLE: if (START) r_state <= SYNC;
        SYNC: begin
          r_state <= RUN;
          r_cyc   <= '0;
        end
        RUN: begin
          r_cyc <= sat_inc(r_cyc);
          if (w_cmp) r_chk_cnt <= sat_inc(r_chk_cnt);
          if (w_mis) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
            if (w_val_mis) r_err_val <= 1'b1;
            if (w_tnt_mis) r_err_tnt <= 1'b1;
            if (!r_err) r_first_err <= r_cyc;
          end
          if (STOP || (w_mis && STOP_ON_ERR)) begin
            r_state <= HALT;
            r_done  <= 1'b1;
          end
        end
        HALT:    r_done  <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ERR       = r_err;
  assign ERR_VAL   = r_err_val;
  assign ERR_TNT   = r_err_tnt;
  assign CHK_CNT   = r_chk_cnt;
  assign ERR_CNT   = r_err_cnt;
  assign FIRST_ERR = r_first_err;
  assign DONE      = r_done;

endmodule

// File: tb/tb_dffsre_ift_monitor.sv
// Directed bench: three monitors (default, 4-bit counters, stop-on-error) watch one driven DFF image.
module tb_dffsre_ift_monitor;

  localparam int TW = 32;

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic          OBS_D = 1'b0;
  logic [TW-1:0] OBS_D_t = '0;
  logic          OBS_EN = 1'b0;
  logic [TW-1:0] OBS_EN_t = '0;
  logic          OBS_SET = 1'b0;
  logic [TW-1:0] OBS_SET_t = '0;
  logic          OBS_CLR = 1'b0;
  logic [TW-1:0] OBS_CLR_t = '0;
  logic [TW-1:0] OBS_CLK_t = '0;
  logic          OBS_Q = 1'b0;
  logic [TW-1:0] OBS_Q_t = '0;

  logic        d_err, d_val, d_tnt, d_done;
  logic [15:0] d_chk, d_ecnt, d_first;
  logic        s_err, s_val, s_tnt, s_done;
  logic [3:0]  s_chk, s_ecnt, s_first;
  logic        h_err, h_val, h_tnt, h_done;
  logic [15:0] h_chk, h_ecnt, h_first;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  dffsre_ift_monitor #(.TW(TW), .CW(16), .STOP_ON_ERR(1'b0)) u_dut (
    .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP),
    .OBS_D(OBS_D), .OBS_D_t(OBS_D_t), .OBS_EN(OBS_EN), .OBS_EN_t(OBS_EN_t),
    .OBS_SET(OBS_SET), .OBS_SET_t(OBS_SET_t), .OBS_CLR(OBS_CLR), .OBS_CLR_t(OBS_CLR_t),
    .OBS_CLK_t(OBS_CLK_t), .OBS_Q(OBS_Q), .OBS_Q_t(OBS_Q_t),
    .ERR(d_err), .ERR_VAL(d_val), .ERR_TNT(d_tnt), .CHK_CNT(d_chk),
    .ERR_CNT(d_ecnt), .FIRST_ERR(d_first), .DONE(d_done)
  );

  dffsre_ift_monitor #(.TW(TW), .CW(4), .STOP_ON_ERR(1'b0)) u_sat (
    .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP),
    .OBS_D(OBS_D), .OBS_D_t(OBS_D_t), .OBS_EN(OBS_EN), .OBS_EN_t(OBS_EN_t),
    .OBS_SET(OBS_SET), .OBS_SET_t(OBS_SET_t), .OBS_CLR(OBS_CLR), .OBS_CLR_t(OBS_CLR_t),
    .OBS_CLK_t(OBS_CLK_t), .OBS_Q(OBS_Q), .OBS_Q_t(OBS_Q_t),
    .ERR(s_err), .ERR_VAL(s_val), .ERR_TNT(s_tnt), .CHK_CNT(s_chk),
    .ERR_CNT(s_ecnt), .FIRST_ERR(s_first), .DONE(s_done)
  );

  dffsre_ift_monitor #(.TW(TW), .CW(16), .STOP_ON_ERR(1'b1)) u_halt (
    .CLK(CLK), .CLR(CLR), .START(START), .STOP(STOP),
    .OBS_D(OBS_D), .OBS_D_t(OBS_D_t), .OBS_EN(OBS_EN), .OBS_EN_t(OBS_EN_t),
    .OBS_SET(OBS_SET), .OBS_SET_t(OBS_SET_t), .OBS_CLR(OBS_CLR), .OBS_CLR_t(OBS_CLR_t),
    .OBS_CLK_t(OBS_CLK_t), .OBS_Q(OBS_Q), .OBS_Q_t(OBS_Q_t),
    .ERR(h_err), .ERR_VAL(h_val), .ERR_TNT(h_tnt), .CHK_CNT(h_chk),
    .ERR_CNT(h_ecnt), .FIRST_ERR(h_first), .DONE(h_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  task automatic idle_inputs();
    START = 0; STOP = 0;
    OBS_D = 0; OBS_D_t = '0; OBS_EN = 0; OBS_EN_t = '0;
    OBS_SET = 0; OBS_SET_t = '0; OBS_CLR = 0; OBS_CLR_t = '0;
    OBS_CLK_t = '0; OBS_Q = 0; OBS_Q_t = '0;
  endtask

  // IDLE->SYNC on the first edge, SYNC loads the model and enters RUN on the second.
  task automatic arm();
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_chk", 32'(d_chk), 0);
    chk("rst_err", 32'(d_err), 0);
    chk("rst_done", 32'(d_done), 0);
    chk("rst_first", 32'(d_first), 0);
    CLR = 1'b0;
    tick();

    // Golden DFF: EN=1, D toggling, D_t=1
    idle_inputs();
    OBS_EN = 1; OBS_D_t = 32'h1;
    arm();
    for (int i = 0; i < 20; i++) begin
      OBS_D = i[0];
      tick();
      OBS_Q = i[0];
      OBS_Q_t = 32'h1;
    end
    chk("gold_chk", 32'(d_chk), 20);
    chk("gold_err", 32'(d_err), 0);
    chk("gold_ecnt", 32'(d_ecnt), 0);
    chk("gold_sat_chk", 32'(s_chk), 15);
    chk("gold_halt_done", 32'(h_done), 0);
    STOP = 1;
    tick();
    STOP = 0;
    chk("stop_done", 32'(d_done), 1);
    chk("stop_chk", 32'(d_chk), 21);
    START = 1;
    tick();
    START = 0;
    tick();
    chk("halt_chk", 32'(d_chk), 21);
    chk("halt_done", 32'(d_done), 1);

    // CLR pulse mid-RUN after mismatches
    do_clr();
    idle_inputs();
    OBS_EN = 1;
    arm();
    OBS_Q = 1;
    tick(3);
    chk("pre_clr_ecnt", 32'(d_ecnt), 3);
    chk("pre_clr_err", 32'(d_err), 1);
    do_clr();
    chk("clr_async_err", 32'(d_err), 0);
    chk("clr_async_chk", 32'(d_chk), 0);
    tick();
    STOP = 1;
    tick();
    STOP = 0;
    tick(2);
    chk("clr_idle_chk", 32'(d_chk), 0);
    chk("clr_idle_err", 32'(d_err), 0);
    chk("clr_idle_done", 32'(d_done), 0);

    // EN=0 with EN_t=4 while the faulty DFF keeps Q_t at 0
    do_clr();
    idle_inputs();
    OBS_EN_t = 32'h4;
    arm();
    tick();
    chk("tnt_r0_chk", 32'(d_chk), 1);
    chk("tnt_r0_err", 32'(d_err), 0);
    tick();
    chk("tnt_err", 32'(d_err), 1);
    chk("tnt_err_tnt", 32'(d_tnt), 1);
    chk("tnt_err_val", 32'(d_val), 0);
    chk("tnt_first", 32'(d_first), 1);
    chk("tnt_ecnt", 32'(d_ecnt), 1);
    chk("tnt_halt_done", 32'(h_done), 1);
    tick();
    chk("tnt_ecnt2", 32'(d_ecnt), 2);
    chk("tnt_first_kept", 32'(d_first), 1);
    chk("tnt_chk3", 32'(d_chk), 3);
    chk("tnt_halt_chk", 32'(h_chk), 2);
    chk("tnt_halt_ecnt", 32'(h_ecnt), 1);

    // SET pulse: two set edges plus one trailing edge are skipped
    do_clr();
    idle_inputs();
    arm();
    OBS_SET = 1; OBS_SET_t = 32'h10;
    OBS_Q = 1; OBS_Q_t = 32'h10;
    tick(2);
    chk("set_skip_chk", 32'(d_chk), 0);
    OBS_SET = 0; OBS_SET_t = '0;
    tick();
    chk("set_trail_chk", 32'(d_chk), 0);
    tick();
    chk("set_cmp_chk", 32'(d_chk), 1);
    chk("set_cmp_err", 32'(d_err), 0);
    tick();
    chk("set_cmp2_chk", 32'(d_chk), 2);
    chk("set_cmp2_err", 32'(d_err), 0);

    // CLR and SET together: clear wins
    do_clr();
    idle_inputs();
    OBS_Q = 1;
    arm();
    OBS_CLR = 1; OBS_CLR_t = 32'h20;
    OBS_SET = 1; OBS_SET_t = 32'h10;
    OBS_Q = 0; OBS_Q_t = 32'h20;
    tick();
    OBS_CLR = 0; OBS_CLR_t = '0;
    OBS_SET = 0; OBS_SET_t = '0;
    tick(2);
    chk("prio_chk", 32'(d_chk), 1);
    chk("prio_err", 32'(d_err), 0);
    chk("prio_val", 32'(d_val), 0);
    chk("prio_tnt", 32'(d_tnt), 0);

    // Q inverted every cycle: saturation and stop-on-error
    do_clr();
    idle_inputs();
    OBS_EN = 1;
    arm();
    OBS_Q = 1;
    tick(20);
    chk("inv_ecnt", 32'(d_ecnt), 20);
    chk("inv_first", 32'(d_first), 0);
    chk("inv_val", 32'(d_val), 1);
    chk("inv_tnt", 32'(d_tnt), 0);
    chk("inv_sat_ecnt", 32'(s_ecnt), 15);
    chk("inv_sat_chk", 32'(s_chk), 15);
    chk("inv_halt_done", 32'(h_done), 1);
    chk("inv_halt_ecnt", 32'(h_ecnt), 1);
    chk("inv_halt_err", 32'(h_err), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
